// File: rtl/updown_ctrl.sv
// Up/down button controller: synchronizes two raw buttons, debounces a single press
// and issues one increment/decrement command per press, saturating at the counter limits.
module updown_ctrl #(
    parameter int unsigned DB_CYCLES = 2,
    parameter int unsigned W         = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         u,
    input  logic         d,
    input  logic [W-1:0] c_in,
    output logic         inc,
    output logic         dec,
    output logic         sat,
    output logic         conflict,
    output logic         busy
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE = 3'd1;
    localparam logic [2:0] ST_ISSUE    = 3'd2;
    localparam logic [2:0] ST_WAIT_REL = 3'd3;
    localparam logic [2:0] ST_CONFLICT = 3'd4;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    logic [1:0]    u_sync_q, u_sync_d;
    logic [1:0]    d_sync_q, d_sync_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          u_s, d_s, held_s;
    logic          at_max_s, at_min_s;

    assign u_s = u_sync_q[1];
    assign d_s = d_sync_q[1];

    // Synchronizer shift and FSM next-state logic.
    always_comb begin
        u_sync_d = {u_sync_q[0], u};
        d_sync_d = {d_sync_q[0], d};
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        held_s   = (dir_q == DIR_UP) ? u_s : d_s;
        case (state_q)
            ST_IDLE: begin
                if (u_s && d_s) begin
                    state_d = ST_CONFLICT;
                end else if (u_s) begin
                    state_d = ST_DEBOUNCE;
                    dir_d   = DIR_UP;
                    cnt_d   = {CW{1'b0}};
                end else if (d_s) begin
                    state_d = ST_DEBOUNCE;
                    dir_d   = DIR_DOWN;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DEBOUNCE: begin
                // cnt stops at CNT_LAST, so it cannot wrap while debouncing.
                if (u_s && d_s) begin
                    state_d = ST_CONFLICT;
                end else if (!held_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL, ST_CONFLICT: begin
                if (!u_s && !d_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, synchronizer and debounce registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_sync_q <= 2'b00;
            d_sync_q <= 2'b00;
            state_q  <= ST_IDLE;
            cnt_q    <= {CW{1'b0}};
            dir_q    <= 1'b0;
        end else begin
            u_sync_q <= u_sync_d;
            d_sync_q <= d_sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
        end
    end

    assign at_max_s = (c_in == {W{1'b1}});
    assign at_min_s = (c_in == {W{1'b0}});

    // Outputs decode from the registered state; the limit check uses c_in of the ISSUE cycle.
    always_comb begin
        inc      = 1'b0;
        dec      = 1'b0;
        sat      = 1'b0;
        conflict = (state_q == ST_CONFLICT);
        busy     = (state_q != ST_IDLE);
        if (state_q == ST_ISSUE) begin
            if (dir_q == DIR_UP) begin
                inc = !at_max_s;
                sat = at_max_s;
            end else begin
                dec = !at_min_s;
                sat = at_min_s;
            end
        end else begin
            sat = 1'b0;
        end
    end

endmodule
